fetch_sequencer: RTL and testbench

//   Front-end fetch stage of the 9-bit CPU: owns the program counter and the

---
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch front end of the 9-bit CPU: program counter, Start/Ack handshake and run enable.
// Programs sit back to back in InstMem; each launch resumes after the previous done word.
module fetch_sequencer #(
  parameter int          PC_W       = 10,
  parameter int          INST_W     = 9,
  parameter int unsigned DONE_INST  = 32'h0000_01FF,
  parameter int unsigned START_ADDR = 32'd0,
  parameter int          CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [INST_W-1:0] Instruction,
  input  logic              BranchEn,
  input  logic              ZeroFlag,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Go,
  output logic              Ack,
  output logic [CNT_W-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT             stateR;
  stateT             stateS;
  logic [PC_W-1:0]   launchAddrR;
  logic [PC_W-1:0]   launchAddrS;
  logic [PC_W-1:0]   progCtrS;
  logic              goS;
  logic              ackS;
  logic [CNT_W-1:0]  cycleCountS;
  logic [PC_W-1:0]   pcPlusOneS;
  logic              isDoneInstS;
  logic              cntAtMaxS;

  assign pcPlusOneS  = ProgCtr + {{(PC_W-1){1'b0}}, 1'b1};
  assign isDoneInstS = (Instruction == INST_W'(DONE_INST));
  assign cntAtMaxS   = (CycleCount == {CNT_W{1'b1}});

  // Next-state and next-output decode; every registered value holds unless a rule moves it
  always_comb begin
    stateS      = stateR;
    launchAddrS = launchAddrR;
    progCtrS    = ProgCtr;
    goS         = Go;
    ackS        = Ack;
    cycleCountS = CycleCount;
    case (stateR)
      IDLE: begin
        if (Start) begin
          stateS = ARMED;
        end else begin
          stateS = IDLE;
        end
      end
      ARMED: begin
        // Launch happens on the release of Start, not on its rise
        if (!Start) begin
          stateS      = RUN;
          progCtrS    = launchAddrR;
          goS         = 1'b1;
          cycleCountS = {CNT_W{1'b0}};
        end else begin
          stateS = ARMED;
        end
      end
      RUN: begin
        if (cntAtMaxS) begin
          cycleCountS = CycleCount;
        end else begin
          cycleCountS = CycleCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        // Done wins over a simultaneous taken branch
        if (isDoneInstS) begin
          stateS      = DONE;
          goS         = 1'b0;
          ackS        = 1'b1;
          launchAddrS = pcPlusOneS;
        end else if (BranchEn && ZeroFlag) begin
          progCtrS = Target;
        end else begin
          progCtrS = pcPlusOneS;
        end
      end
      DONE: begin
        if (Start) begin
          stateS = ARMED;
          ackS   = 1'b0;
        end else begin
          stateS = DONE;
        end
      end
      default: begin
        stateS = IDLE;
        goS    = 1'b0;
        ackS   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateR      <= IDLE;
      launchAddrR <= PC_W'(START_ADDR);
      ProgCtr     <= {PC_W{1'b0}};
      Go          <= 1'b0;
      Ack         <= 1'b0;
      CycleCount  <= {CNT_W{1'b0}};
    end else begin
      stateR      <= stateS;
      launchAddrR <= launchAddrS;
      ProgCtr     <= progCtrS;
      Go          <= goS;
      Ack         <= ackS;
      CycleCount  <= cycleCountS;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic [8:0] Instruction;
  logic       BranchEn;
  logic       ZeroFlag;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic       Go;
  logic       Ack;
  logic [15:0] CycleCount;

  int total;
  int bad;

  // Behavioural model: where the program is, plus PC, next launch point and cycle tally
  bit mRunning;
  bit mArmed;
  bit mFinished;
  int mPc;
  int mLaunch;
  int mCount;

  fetch_sequencer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Instruction(Instruction),
    .BranchEn   (BranchEn),
    .ZeroFlag   (ZeroFlag),
    .Target     (Target),
    .ProgCtr    (ProgCtr),
    .Go         (Go),
    .Ack        (Ack),
    .CycleCount (CycleCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       start;
    logic [8:0] inst;
    logic       br;
    logic       zf;
    logic [9:0] tgt;
    logic [9:0] expPc;
    logic       expGo;
    logic       expAck;
  } vecT;

  vecT vecs[15];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRunning  = 1'b0;
    mArmed    = 1'b0;
    mFinished = 1'b0;
    mPc       = 0;
    mLaunch   = 0;
    mCount    = 0;
  endtask

  task automatic modelEdge();
    if (mRunning) begin
      if (mCount < 65535) mCount = mCount + 1;
      if (Instruction == 9'h1FF) begin
        mRunning  = 1'b0;
        mFinished = 1'b1;
        mLaunch   = (mPc + 1) % 1024;
      end else if (BranchEn && ZeroFlag) begin
        mPc = int'(Target);
      end else begin
        mPc = (mPc + 1) % 1024;
      end
    end else if (mArmed) begin
      if (!Start) begin
        mArmed   = 1'b0;
        mRunning = 1'b1;
        mPc      = mLaunch;
        mCount   = 0;
      end
    end else if (Start) begin
      mArmed    = 1'b1;
      mFinished = 1'b0;
    end
  endtask

  task automatic checkModel();
    cmp("model_pc",  32'(ProgCtr),    32'(mPc));
    cmp("model_go",  32'(Go),         32'(mRunning));
    cmp("model_ack", 32'(Ack),        32'(mFinished));
    cmp("model_cnt", 32'(CycleCount), 32'(mCount));
  endtask

  task automatic step();
    @(posedge Clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic setIn(input logic s, input logic [8:0] i, input logic b, input logic z,
                       input logic [9:0] t);
    Start       = s;
    Instruction = i;
    BranchEn    = b;
    ZeroFlag    = z;
    Target      = t;
  endtask

  // Asserts reset between clock edges; caller sits at posedge+1
  task automatic asyncReset();
    #3;
    Reset_n = 1'b0;
    modelReset();
    #1;
    checkModel();
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    modelReset();
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    Reset_n = 1'b0;
    #12;
    cmp("reset_pc",  32'(ProgCtr),    32'h0);
    cmp("reset_go",  32'(Go),         32'h0);
    cmp("reset_ack", 32'(Ack),        32'h0);
    cmp("reset_cnt", 32'(CycleCount), 32'h0);
    Reset_n = 1'b1;

    vecs[0]  = '{1'b1, 9'h000, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 9'h000, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 9'h012, 1'b0, 1'b0, 10'h000, 10'h001, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 9'h034, 1'b0, 1'b1, 10'h100, 10'h002, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 9'h056, 1'b1, 1'b0, 10'h200, 10'h003, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 9'h078, 1'b1, 1'b0, 10'h02C, 10'h004, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 9'h09A, 1'b1, 1'b1, 10'h003, 10'h003, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 9'h0BC, 1'b1, 1'b1, 10'h02C, 10'h02C, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 9'h0DE, 1'b0, 1'b0, 10'h000, 10'h02D, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 9'h1FE, 1'b0, 1'b0, 10'h000, 10'h02E, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 9'h1FF, 1'b1, 1'b1, 10'h155, 10'h02E, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 9'h000, 1'b0, 1'b0, 10'h000, 10'h02E, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 9'h000, 1'b0, 1'b0, 10'h000, 10'h02E, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 9'h000, 1'b0, 1'b0, 10'h000, 10'h02E, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 9'h000, 1'b0, 1'b0, 10'h000, 10'h02F, 1'b1, 1'b0};

    for (int k = 0; k < 15; k++) begin
      setIn(vecs[k].start, vecs[k].inst, vecs[k].br, vecs[k].zf, vecs[k].tgt);
      step();
      cmp($sformatf("vec%0d_pc", k),  32'(ProgCtr), 32'(vecs[k].expPc));
      cmp($sformatf("vec%0d_go", k),  32'(Go),      32'(vecs[k].expGo));
      cmp($sformatf("vec%0d_ack", k), 32'(Ack),     32'(vecs[k].expAck));
    end

    // Asynchronous reset in the middle of a running program
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    asyncReset();
    cmp("arst_pc",  32'(ProgCtr), 32'h0);
    cmp("arst_go",  32'(Go),      32'h0);
    cmp("arst_ack", 32'(Ack),     32'h0);
    @(posedge Clk);
    #1;
    setIn(1'b1, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    cmp("relaunch_pc", 32'(ProgCtr), 32'h0);
    cmp("relaunch_go", 32'(Go),      32'h1);

    // Straight-line program ending at 0x10, then resume at the following word
    for (int k = 0; k < 16; k++) begin
      setIn(1'b0, 9'(k), 1'b0, 1'b0, 10'h000);
      step();
    end
    setIn(1'b0, 9'h1FF, 1'b0, 1'b0, 10'h000);
    step();
    cmp("done_ack", 32'(Ack),        32'h1);
    cmp("done_go",  32'(Go),         32'h0);
    cmp("done_pc",  32'(ProgCtr),    32'h010);
    cmp("done_cnt", 32'(CycleCount), 32'd17);
    setIn(1'b1, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    cmp("ackdrop_ack", 32'(Ack), 32'h0);
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    cmp("resume_pc", 32'(ProgCtr), 32'h011);
    cmp("resume_go", 32'(Go),      32'h1);

    // PC wrap and launch-address wrap at the top of InstMem
    setIn(1'b0, 9'h000, 1'b1, 1'b1, 10'h3FF);
    step();
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    cmp("wrap_pc", 32'(ProgCtr), 32'h000);
    setIn(1'b0, 9'h000, 1'b1, 1'b1, 10'h3FF);
    step();
    setIn(1'b0, 9'h1FF, 1'b0, 1'b0, 10'h000);
    step();
    cmp("top_done_pc", 32'(ProgCtr), 32'h3FF);
    setIn(1'b1, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    setIn(1'b0, 9'h000, 1'b0, 1'b0, 10'h000);
    step();
    cmp("launch_wrap_pc", 32'(ProgCtr), 32'h000);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      setIn(($urandom_range(0, 7) == 0),
            ($urandom_range(0, 24) == 0) ? 9'h1FF : 9'($urandom_range(0, 510)),
            1'($urandom), 1'($urandom), 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 499) == 0) begin
        asyncReset();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
